// File: rtl/rx_control_module.sv
// UART receive controller: start-bit qualification, 8-bit LSB-first capture, stop check.
// Build with RX_PARITY_EN defined for even-parity frames and the Parity_Err_Sig output.
module rx_control_module #(
    parameter int unsigned BPS_CNT = 434
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       H2L_Sig,
    input  logic       Rx_Pin_In,
    input  logic       Rx_En_Sig,
    output logic [7:0] Rx_Data,
`ifdef RX_PARITY_EN
    output logic       Rx_Done_Sig,
    output logic       Parity_Err_Sig
`else
    output logic       Rx_Done_Sig
`endif
);

    // state  | meaning
    // IDLE   | waiting for a start edge while enabled
    // START  | qualifying the start bit at mid-bit
    // DATA   | capturing 8 data bits, LSB first
    // PARITY | capturing the even-parity bit
    // STOP   | checking the stop bit at mid-bit
    // DONE   | byte delivered, done pulse high

    localparam logic [15:0] CNT_MAX = 16'(BPS_CNT - 1);
    localparam logic [15:0] CNT_MID = 16'(BPS_CNT / 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        sample_pt;
    logic        bit_end;
    logic        stop_ok;

    assign sample_pt = (cnt == CNT_MID);
    assign bit_end   = (cnt == CNT_MAX);
    assign stop_ok   = (state == STOP) && sample_pt && Rx_Pin_In;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (H2L_Sig && Rx_En_Sig) state_nxt = START;
            end
            START: begin
                if (sample_pt && Rx_Pin_In) state_nxt = IDLE;
                else if (bit_end)           state_nxt = DATA;
            end
            DATA: begin
`ifdef RX_PARITY_EN
                if (bit_end && (bit_idx == 3'd7)) state_nxt = PARITY;
`else
                if (bit_end && (bit_idx == 3'd7)) state_nxt = STOP;
`endif
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (sample_pt) state_nxt = Rx_Pin_In ? DONE : IDLE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The counter restarts on every state change and every bit boundary.
    always_comb begin
        cnt_nxt = cnt + 16'd1;
        if ((state == IDLE) || (state_nxt != state) || bit_end) cnt_nxt = '0;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            bit_idx     <= '0;
            shift       <= '0;
            Rx_Data     <= '0;
            Rx_Done_Sig <= 1'b0;
        end else begin
            if (state == IDLE)                 bit_idx <= '0;
            else if ((state == DATA) && bit_end) bit_idx <= bit_idx + 3'd1;
            if ((state == DATA) && sample_pt)  shift <= {Rx_Pin_In, shift[7:1]};
            // Outputs register on entry to DONE so they are valid during that cycle.
            Rx_Done_Sig <= stop_ok;
            if (stop_ok) Rx_Data <= shift;
        end
    end

`ifdef RX_PARITY_EN
    logic parity_bit;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            parity_bit     <= 1'b0;
            Parity_Err_Sig <= 1'b0;
        end else begin
            if ((state == PARITY) && sample_pt) parity_bit <= Rx_Pin_In;
            Parity_Err_Sig <= stop_ok && ((^shift) ^ parity_bit);
        end
    end
`endif

endmodule

// File: tb/tb_rx_control_module.sv
// Directed bench for rx_control_module at BPS_CNT=8; parity steps enabled with RX_PARITY_EN.
module tb_rx_control_module;

    localparam int B = 8;
`ifdef RX_PARITY_EN
    localparam int NBITS = 11;
    localparam int LAT   = 10 * B - B / 2 + 2 + B;
`else
    localparam int NBITS = 10;
    localparam int LAT   = 10 * B - B / 2 + 2;
`endif

    logic       CLK;
    logic       RST_n;
    logic       H2L_Sig;
    logic       Rx_Pin_In;
    logic       Rx_En_Sig;
    logic [7:0] Rx_Data;
    logic       Rx_Done_Sig;
`ifdef RX_PARITY_EN
    logic       Parity_Err_Sig;
    logic       perr_at_done;
`endif

    int total = 0;
    int bad   = 0;
    int cyc;
    int done_cnt;
    int done_cyc;

    rx_control_module #(.BPS_CNT(B)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .H2L_Sig    (H2L_Sig),
        .Rx_Pin_In  (Rx_Pin_In),
        .Rx_En_Sig  (Rx_En_Sig),
        .Rx_Data    (Rx_Data),
`ifdef RX_PARITY_EN
        .Rx_Done_Sig(Rx_Done_Sig),
        .Parity_Err_Sig(Parity_Err_Sig)
`else
        .Rx_Done_Sig(Rx_Done_Sig)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (Rx_Done_Sig === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
`ifdef RX_PARITY_EN
            perr_at_done = Parity_Err_Sig;
`endif
        end
    endtask

    // Drives one frame; cycle 0 carries the H2L pulse together with the start bit.
    task automatic frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                         input logic en, input int drop_at, input int h2l_at,
                         input int rst_at, input int gap);
        logic bv;
        int   c;
        done_cnt = 0;
        done_cyc = -1;
        cyc      = 0;
        for (int b = 0; b < NBITS; b++) begin
            if (b == 0)              bv = 1'b0;
            else if (b <= 8)         bv = d[b-1];
            else if (b == NBITS - 1) bv = stop_b;
            else                     bv = par_b;
            for (int k = 0; k < B; k++) begin
                c = b * B + k;
                Rx_Pin_In = bv;
                H2L_Sig   = (c == 0) || (c == h2l_at);
                if (c == 0)       Rx_En_Sig = en;
                if (c == drop_at) Rx_En_Sig = 1'b0;
                if (c == rst_at) begin
                    RST_n = 1'b0;
                    #1;
                    chk("rst_mid_data", {24'h0, Rx_Data}, 32'h00);
                    chk("rst_mid_done", {31'h0, Rx_Done_Sig}, 32'h0);
`ifdef RX_PARITY_EN
                    chk("rst_mid_perr", {31'h0, Parity_Err_Sig}, 32'h0);
`endif
                end else if (c == rst_at + 1) begin
                    RST_n = 1'b1;
                end
                tick();
            end
        end
        Rx_Pin_In = 1'b1;
        H2L_Sig   = 1'b0;
        Rx_En_Sig = 1'b1;
        repeat (gap) tick();
    endtask

    initial begin
        RST_n     = 1'b0;
        H2L_Sig   = 1'b0;
        Rx_Pin_In = 1'b1;
        Rx_En_Sig = 1'b1;
        cyc       = 0;
        done_cnt  = 0;
        done_cyc  = -1;
`ifdef RX_PARITY_EN
        perr_at_done = 1'b0;
`endif
        repeat (3) tick();
        chk("reset_data", {24'h0, Rx_Data}, 32'h00);
        chk("reset_done", {31'h0, Rx_Done_Sig}, 32'h0);
`ifdef RX_PARITY_EN
        chk("reset_perr", {31'h0, Parity_Err_Sig}, 32'h0);
`endif
        RST_n = 1'b1;
        repeat (3) tick();

        frame(8'hA5, 1'b1, ^8'hA5, 1'b1, -1, -1, -1, 4);
        chk("a5_pulses", done_cnt, 1);
        chk("a5_latency", done_cyc, LAT);
        chk("a5_data", {24'h0, Rx_Data}, 32'hA5);

        // false start: line low only two cycles
        done_cnt = 0;
        cyc = 0;
        Rx_Pin_In = 1'b0;
        H2L_Sig   = 1'b1;
        tick();
        H2L_Sig = 1'b0;
        tick();
        Rx_Pin_In = 1'b1;
        repeat (NBITS * B + 4) tick();
        chk("false_start_pulses", done_cnt, 0);
        chk("false_start_data", {24'h0, Rx_Data}, 32'hA5);

        frame(8'h3C, 1'b0, ^8'h3C, 1'b1, -1, -1, -1, 4);
        chk("framing_err_pulses", done_cnt, 0);
        chk("framing_err_data", {24'h0, Rx_Data}, 32'hA5);

        // stray H2L mid-frame must be ignored
        frame(8'h5A, 1'b1, ^8'h5A, 1'b1, -1, 20, -1, 4);
        chk("5a_pulses", done_cnt, 1);
        chk("5a_latency", done_cyc, LAT);
        chk("5a_data", {24'h0, Rx_Data}, 32'h5A);

        frame(8'hFF, 1'b1, ^8'hFF, 1'b0, -1, -1, -1, 4);
        chk("disabled_pulses", done_cnt, 0);
        chk("disabled_data", {24'h0, Rx_Data}, 32'h5A);

        frame(8'h81, 1'b1, ^8'h81, 1'b1, 3, -1, -1, 4);
        chk("en_drop_pulses", done_cnt, 1);
        chk("en_drop_data", {24'h0, Rx_Data}, 32'h81);

        // reset lands inside data bit 4
        frame(8'hC3, 1'b1, ^8'hC3, 1'b1, -1, -1, 42, 4);
        chk("rst_frame_pulses", done_cnt, 0);
        chk("rst_frame_data", {24'h0, Rx_Data}, 32'h00);

        frame(8'h0F, 1'b1, ^8'h0F, 1'b1, -1, -1, -1, 4);
        chk("0f_pulses", done_cnt, 1);
        chk("0f_latency", done_cyc, LAT);
        chk("0f_data", {24'h0, Rx_Data}, 32'h0F);

        // back-to-back frames with no idle gap
        frame(8'h33, 1'b1, ^8'h33, 1'b1, -1, -1, -1, 0);
        chk("b2b_first_pulses", done_cnt, 1);
        chk("b2b_first_data", {24'h0, Rx_Data}, 32'h33);
        frame(8'hCC, 1'b1, ^8'hCC, 1'b1, -1, -1, -1, 6);
        chk("b2b_second_pulses", done_cnt, 1);
        chk("b2b_second_latency", done_cyc, LAT);
        chk("b2b_second_data", {24'h0, Rx_Data}, 32'hCC);
        chk("hold_data", {24'h0, Rx_Data}, 32'hCC);

`ifdef RX_PARITY_EN
        frame(8'h07, 1'b1, 1'b1, 1'b1, -1, -1, -1, 4);
        chk("par_ok_pulses", done_cnt, 1);
        chk("par_ok_perr", {31'h0, perr_at_done}, 32'h0);
        chk("par_ok_data", {24'h0, Rx_Data}, 32'h07);
        frame(8'h07, 1'b1, 1'b0, 1'b1, -1, -1, -1, 4);
        chk("par_bad_pulses", done_cnt, 1);
        chk("par_bad_perr", {31'h0, perr_at_done}, 32'h1);
        chk("par_bad_data", {24'h0, Rx_Data}, 32'h07);
        chk("par_err_cleared", {31'h0, Parity_Err_Sig}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_control_module.md
RX_CONTROL_MODULE -- requirements
Module: rx_control_module

Interface
REQ-001 SHALL have parameter BPS_CNT, default 434, meaning clock cycles per bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port CLK  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port RST_n  input  1  reset; asynchronous, active-low, the only reset.
REQ-004 SHALL have port H2L_Sig  input  1  one-cycle start-edge pulse from the falling-edge detector stage.
REQ-005 SHALL have port Rx_Pin_In  input  1  serial line, already synchronised upstream; idle high.
REQ-006 SHALL have port Rx_En_Sig  input  1  receive enable; frames start only while high.
REQ-007 SHALL have port Rx_Data  output  8  last received byte.
REQ-008 SHALL have port Rx_Done_Sig  output  1  one-cycle pulse, Rx_Data valid.
REQ-009 SHALL have port Parity_Err_Sig  output  1  present only when RX_PARITY_EN is defined (REQ-026).

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP, DONE (plus PARITY per REQ-026).
REQ-011 SHALL use one bit-period counter cnt, cleared to 0 on every state/bit entry, counting 0..BPS_CNT-1, then wrapping to 0.
REQ-012 SHALL define the sample point as cnt == BPS_CNT/2 (integer division).
REQ-013 IDLE: on H2L_Sig=1 and Rx_En_Sig=1 in the same cycle, SHALL enter START next cycle; H2L_Sig SHALL be ignored in every other state.
REQ-014 START: at sample point, Rx_Pin_In=1 SHALL return to IDLE (false start, no outputs change); Rx_Pin_In=0 SHALL continue, and at cnt==BPS_CNT-1 enter DATA.
REQ-015 DATA: SHALL sample 8 bits LSB first at each sample point into a shift register, advancing bit index at cnt==BPS_CNT-1; after bit 7 enter STOP.
REQ-016 STOP: at sample point, Rx_Pin_In=1 SHALL enter DONE next cycle; Rx_Pin_In=0 (framing error) SHALL return to IDLE with Rx_Data unchanged and no done pulse.
REQ-017 DONE: SHALL load Rx_Data from shift register and assert Rx_Done_Sig for exactly one cycle, then enter IDLE (half stop bit remaining permits back-to-back frames).
REQ-018 Rx_Data SHALL hold its value between Rx_Done_Sig pulses.
REQ-019 Rx_En_Sig falling mid-frame SHALL NOT abort the frame; it gates only IDLE->START.
REQ-020 Latency: Rx_Done_Sig SHALL assert (10*BPS_CNT - BPS_CNT/2 + 2) cycles after the H2L_Sig cycle without parity; add BPS_CNT with parity.

Reset
REQ-021 RST_n low SHALL asynchronously force state IDLE, cnt=0, bit index=0, shift register=0x00.
REQ-022 Reset values: Rx_Data=0x00, Rx_Done_Sig=0, Parity_Err_Sig=0.
REQ-023 Reset asserted mid-frame SHALL discard the frame; after release, the block SHALL wait in IDLE for a new H2L_Sig.

Configuration
REQ-024 Macro RX_PARITY_EN SHALL select even-parity reception.
REQ-025 Without RX_PARITY_EN: frame = start, 8 data, stop; port Parity_Err_Sig SHALL NOT exist.
REQ-026 With RX_PARITY_EN: state PARITY between DATA and STOP samples one parity bit at sample point; Parity_Err_Sig SHALL be asserted in the DONE cycle (with Rx_Done_Sig) when XOR of 8 data bits and parity bit is 1, else 0; byte still delivered.

Verification (BPS_CNT=8 for simulation)
REQ-027 Frame 0xA5 (LSB first, stop=1) -> single Rx_Done_Sig pulse, Rx_Data=0xA5, at latency per REQ-020.
REQ-028 Rx_Pin_In low 2 cycles then high, with H2L_Sig pulse -> return to IDLE, no Rx_Done_Sig, Rx_Data unchanged.
REQ-029 Frame 0x3C with stop=0 -> no Rx_Done_Sig, Rx_Data keeps prior 0xA5; subsequent valid frame 0x5A received correctly.
REQ-030 Rx_En_Sig=0 during H2L_Sig of frame 0xFF -> no reception; Rx_En_Sig dropped after START of frame 0x81 -> 0x81 received.
REQ-031 RST_n pulsed low during DATA bit 4 -> all outputs at reset values, next frame 0x0F received correctly.
REQ-032 With RX_PARITY_EN: 0x07 with parity 1 -> Rx_Done_Sig and Parity_Err_Sig=0; with parity 0 -> Parity_Err_Sig=1, Rx_Data=0x07.
